// File: rtl/booth_dot_accumulator.sv
// Sums LEN consecutive signed Booth products into a saturating dot product and
// presents it on a valid/ready handshake, with a one-entry skid for late products.
module booth_dot_accumulator #(
    parameter int N     = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 12,
    localparam int CW   = $clog2(LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [2*N-1:0]     product_in,
    input  logic               done_in,
    output logic [ACC_W-1:0]   acc_out,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic               sat_out,
    output logic               in_full,
    output logic               drop_err,
    output logic [CW-1:0]      term_cnt
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             r_state;
    logic               r_done_q;
    logic [ACC_W-1:0]   r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_vsat;
    logic               r_valid;
    logic               r_sat_out;
    logic [2*N-1:0]     r_pend;
    logic               r_full;
    logic               r_drop;

    state_t             w_state_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_vsat_nxt;
    logic               w_valid_nxt;
    logic               w_sat_out_nxt;
    logic [2*N-1:0]     w_pend_nxt;
    logic               w_full_nxt;
    logic               w_drop_nxt;

    logic               w_arrival;
    logic [ACC_W-1:0]   w_term;
    logic [ACC_W-1:0]   w_pend_ext;
    logic [ACC_W:0]     w_add;
    logic [ACC_W:0]     w_pair;

    // Returns {clamped, value}; overflow shows as disagreement of the top two sum bits.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    assign w_arrival  = done_in & ~r_done_q;
    assign w_term     = ACC_W'($signed(product_in));
    assign w_pend_ext = ACC_W'($signed(r_pend));
    assign w_add      = sat_add(r_acc, w_term);
    assign w_pair     = sat_add(w_pend_ext, w_term);

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_vsat_nxt    = r_vsat;
        w_valid_nxt   = r_valid;
        w_sat_out_nxt = r_sat_out;
        w_pend_nxt    = r_pend;
        w_full_nxt    = r_full;
        w_drop_nxt    = r_drop;

        if (clear) begin
            w_state_nxt   = ACCUM;
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_vsat_nxt    = 1'b0;
            w_valid_nxt   = 1'b0;
            w_sat_out_nxt = 1'b0;
            w_full_nxt    = 1'b0;
            w_drop_nxt    = 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_arrival) begin
                        w_acc_nxt  = w_add[ACC_W-1:0];
                        w_vsat_nxt = r_vsat | w_add[ACC_W];
                        w_cnt_nxt  = r_cnt + CW'(1);
                        if (r_cnt == CW'(LEN - 1)) begin
                            w_state_nxt   = HOLD;
                            w_valid_nxt   = 1'b1;
                            w_sat_out_nxt = r_vsat | w_add[ACC_W];
                        end
                    end
                end
                HOLD: begin
                    // A new vector seeds from the skid entry first, then any same-cycle arrival.
                    if (r_valid && acc_ready) begin
                        w_state_nxt   = ACCUM;
                        w_valid_nxt   = 1'b0;
                        w_sat_out_nxt = 1'b0;
                        w_vsat_nxt    = 1'b0;
                        w_full_nxt    = 1'b0;
                        case ({r_full, w_arrival})
                            2'b00: begin
                                w_acc_nxt = '0;
                                w_cnt_nxt = '0;
                            end
                            2'b10: begin
                                w_acc_nxt = w_pend_ext;
                                w_cnt_nxt = CW'(1);
                            end
                            2'b01: begin
                                w_acc_nxt = w_term;
                                w_cnt_nxt = CW'(1);
                            end
                            default: begin
                                w_acc_nxt  = w_pair[ACC_W-1:0];
                                w_vsat_nxt = w_pair[ACC_W];
                                w_cnt_nxt  = CW'(2);
                                if (LEN == 2) begin
                                    w_state_nxt   = HOLD;
                                    w_valid_nxt   = 1'b1;
                                    w_sat_out_nxt = w_pair[ACC_W];
                                end
                            end
                        endcase
                    end else if (w_arrival) begin
                        if (!r_full) begin
                            w_pend_nxt = product_in;
                            w_full_nxt = 1'b1;
                        end else begin
                            w_drop_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    // done_q tracks done_in even through clear so a held level is never re-counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ACCUM;
            r_done_q  <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_vsat    <= 1'b0;
            r_valid   <= 1'b0;
            r_sat_out <= 1'b0;
            r_pend    <= '0;
            r_full    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done_q  <= done_in;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_vsat    <= w_vsat_nxt;
            r_valid   <= w_valid_nxt;
            r_sat_out <= w_sat_out_nxt;
            r_pend    <= w_pend_nxt;
            r_full    <= w_full_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    assign acc_out   = r_acc;
    assign acc_valid = r_valid;
    assign sat_out   = r_sat_out;
    assign in_full   = r_full;
    assign drop_err  = r_drop;
    assign term_cnt  = r_cnt;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Drives three accumulator configurations (LEN4/ACC12, LEN4/ACC8, LEN2/ACC12) with
// one shared product stream and checks each against its own arithmetic model.
module tb_booth_dot_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       doneIn = 1'b0;
    logic       accReady = 1'b0;
    logic [7:0] productIn = '0;
    bit         cmpEn = 1'b0;

    int nChecks = 0;
    int nErrors = 0;

    logic [11:0] accOutA;
    logic [7:0]  accOutB;
    logic [11:0] accOutC;
    logic        validA, validB, validC;
    logic        satA, satB, satC;
    logic        fullA, fullB, fullC;
    logic        dropA, dropB, dropC;
    logic [2:0]  cntA, cntB;
    logic [1:0]  cntC;

    always #5 clk = ~clk;

    booth_dot_accumulator #(.N(4), .LEN(4), .ACC_W(12)) uA (
        .clk(clk), .rst(rst), .clear(clear), .product_in(productIn), .done_in(doneIn),
        .acc_out(accOutA), .acc_valid(validA), .acc_ready(accReady), .sat_out(satA),
        .in_full(fullA), .drop_err(dropA), .term_cnt(cntA));

    booth_dot_accumulator #(.N(4), .LEN(4), .ACC_W(8)) uB (
        .clk(clk), .rst(rst), .clear(clear), .product_in(productIn), .done_in(doneIn),
        .acc_out(accOutB), .acc_valid(validB), .acc_ready(accReady), .sat_out(satB),
        .in_full(fullB), .drop_err(dropB), .term_cnt(cntB));

    booth_dot_accumulator #(.N(4), .LEN(2), .ACC_W(12)) uC (
        .clk(clk), .rst(rst), .clear(clear), .product_in(productIn), .done_in(doneIn),
        .acc_out(accOutC), .acc_valid(validC), .acc_ready(accReady), .sat_out(satC),
        .in_full(fullC), .drop_err(dropC), .term_cnt(cntC));

    // Model state: one entry per instance, plain integers and flags.
    int mAcc[3];
    int mCnt[3];
    bit mValid[3];
    bit mVecSat[3];
    bit mSatOut[3];
    bit mHasPend[3];
    int mPendVal[3];
    bit mDrop[3];
    bit mDoneQ;

    function automatic int lenOf(input int k);
        return (k == 2) ? 2 : 4;
    endfunction

    function automatic int widthOf(input int k);
        return (k == 1) ? 8 : 12;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mAcc[k] = 0; mCnt[k] = 0; mValid[k] = 0; mVecSat[k] = 0;
            mSatOut[k] = 0; mHasPend[k] = 0; mPendVal[k] = 0; mDrop[k] = 0;
        end
        mDoneQ = 0;
    endtask

    task automatic addTerm(input int k, input int p);
        int hi;
        int lo;
        int s;
        hi = (1 << (widthOf(k) - 1)) - 1;
        lo = -(1 << (widthOf(k) - 1));
        s = mAcc[k] + p;
        if (s > hi) begin s = hi; mVecSat[k] = 1; end
        else if (s < lo) begin s = lo; mVecSat[k] = 1; end
        mAcc[k] = s;
        mCnt[k] = mCnt[k] + 1;
        if (mCnt[k] == lenOf(k)) begin
            mValid[k] = 1;
            mSatOut[k] = mVecSat[k];
        end
    endtask

    task automatic modelEdge(input int k, input int p, input bit arr);
        if (clear) begin
            mAcc[k] = 0; mCnt[k] = 0; mValid[k] = 0; mVecSat[k] = 0;
            mSatOut[k] = 0; mHasPend[k] = 0; mDrop[k] = 0;
        end else if (!mValid[k]) begin
            if (arr) addTerm(k, p);
        end else if (accReady) begin
            mValid[k] = 0; mSatOut[k] = 0; mAcc[k] = 0; mCnt[k] = 0; mVecSat[k] = 0;
            if (mHasPend[k]) begin
                mHasPend[k] = 0;
                addTerm(k, mPendVal[k]);
            end
            if (arr) addTerm(k, p);
        end else if (arr) begin
            if (!mHasPend[k]) begin
                mHasPend[k] = 1;
                mPendVal[k] = p;
            end else begin
                mDrop[k] = 1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            modelReset();
        end else begin
            bit arr;
            int p;
            arr = doneIn && !mDoneQ;
            p = int'($signed(productIn));
            for (int k = 0; k < 3; k++) modelEdge(k, p, arr);
            mDoneQ = doneIn;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic compareInst(input int k, input int acc, input logic v, input logic s,
                               input logic f, input logic d, input int c);
        checkOutput($sformatf("u%0d.acc_valid", k), int'(v), int'(mValid[k]));
        checkOutput($sformatf("u%0d.acc_out", k), acc, mAcc[k]);
        checkOutput($sformatf("u%0d.sat_out", k), int'(s), int'(mSatOut[k]));
        checkOutput($sformatf("u%0d.in_full", k), int'(f), int'(mHasPend[k]));
        checkOutput($sformatf("u%0d.drop_err", k), int'(d), int'(mDrop[k]));
        checkOutput($sformatf("u%0d.term_cnt", k), c, mCnt[k]);
    endtask

    always @(negedge clk) begin
        if (cmpEn) begin
            compareInst(0, int'($signed(accOutA)), validA, satA, fullA, dropA, int'(cntA));
            compareInst(1, int'($signed(accOutB)), validB, satB, fullB, dropB, int'(cntB));
            compareInst(2, int'($signed(accOutC)), validC, satC, fullC, dropC, int'(cntC));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int p, input int hi);
        productIn = 8'(p);
        doneIn = 1'b1;
        repeat (hi) step();
        doneIn = 1'b0;
        step();
    endtask

    // Leaves the bench just after the edge that registers this product.
    task automatic feedLast(input int p);
        productIn = 8'(p);
        doneIn = 1'b1;
        step();
        doneIn = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #1;
        cmpEn = 1'b1;
        doReset();
        checkOutput("reset.acc_out", int'($signed(accOutA)), 0);
        checkOutput("reset.acc_valid", int'(validA), 0);
        checkOutput("reset.term_cnt", int'(cntA), 0);

        // Basic dot product with a ready consumer.
        accReady = 1'b1;
        applyStimulus(49, 1);
        applyStimulus(-56, 1);
        applyStimulus(64, 1);
        feedLast(10);
        checkOutput("p1.acc_valid", int'(validA), 1);
        checkOutput("p1.acc_out", int'($signed(accOutA)), 67);
        checkOutput("p1.sat_out", int'(satA), 0);
        checkOutput("p1.term_cnt", int'(cntA), 4);
        step();
        checkOutput("p1.valid_one_cycle", int'(validA), 0);

        // Long done levels under back-pressure, then skid capture and drop.
        accReady = 1'b0;
        applyStimulus(5, 10);
        applyStimulus(5, 10);
        applyStimulus(5, 10);
        applyStimulus(5, 10);
        checkOutput("p2.acc_out", int'($signed(accOutA)), 20);
        checkOutput("p2.acc_valid", int'(validA), 1);
        applyStimulus(7, 1);
        checkOutput("p4.in_full", int'(fullA), 1);
        checkOutput("p4.drop_err_before", int'(dropA), 0);
        applyStimulus(3, 1);
        checkOutput("p4.drop_err", int'(dropA), 1);
        checkOutput("p4.acc_held", int'($signed(accOutA)), 20);
        accReady = 1'b1;
        step();
        checkOutput("p4.new_acc", int'($signed(accOutA)), 7);
        checkOutput("p4.new_cnt", int'(cntA), 1);
        checkOutput("p4.in_full_after", int'(fullA), 0);
        checkOutput("p4.drop_sticky", int'(dropA), 1);

        // clear while done_in stays high must not produce a second count.
        productIn = 8'(4);
        doneIn = 1'b1;
        step();
        checkOutput("p2.cnt_before_clear", int'(cntA), 2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        step();
        checkOutput("p2.cnt_after_clear", int'(cntA), 0);
        checkOutput("p2.drop_after_clear", int'(dropA), 0);
        doneIn = 1'b0;
        step();

        // Saturation on the 8-bit accumulator, then a clean vector.
        doReset();
        applyStimulus(64, 1);
        applyStimulus(64, 1);
        applyStimulus(64, 1);
        feedLast(-1);
        checkOutput("p3.sat_acc", int'($signed(accOutB)), 126);
        checkOutput("p3.sat_flag", int'(satB), 1);
        checkOutput("p3.wide_acc", int'($signed(accOutA)), 191);
        checkOutput("p3.wide_sat", int'(satA), 0);
        step();
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        feedLast(1);
        checkOutput("p3.next_acc", int'($signed(accOutB)), 4);
        checkOutput("p3.next_sat", int'(satB), 0);
        step();

        // Handshake coinciding with an arrival while a product is pending.
        doReset();
        accReady = 1'b0;
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        applyStimulus(7, 1);
        checkOutput("p5.pending", int'(fullA), 1);
        accReady = 1'b1;
        feedLast(-2);
        checkOutput("p5.pair_acc", int'($signed(accOutA)), 5);
        checkOutput("p5.pair_cnt", int'(cntA), 2);
        checkOutput("p5.pair_valid", int'(validA), 0);
        step();

        // Same case on LEN=2 returns straight to a valid result.
        doReset();
        accReady = 1'b0;
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        applyStimulus(7, 1);
        accReady = 1'b1;
        feedLast(-2);
        checkOutput("p5.len2_valid", int'(validC), 1);
        checkOutput("p5.len2_acc", int'($signed(accOutC)), 5);
        checkOutput("p5.len2_cnt", int'(cntC), 2);
        step();

        // Asynchronous reset mid-vector discards the partial sum.
        doReset();
        applyStimulus(9, 1);
        applyStimulus(9, 1);
        rst = 1'b1;
        #2;
        checkOutput("p6.rst_acc", int'($signed(accOutA)), 0);
        checkOutput("p6.rst_cnt", int'(cntA), 0);
        checkOutput("p6.rst_valid", int'(validA), 0);
        step();
        rst = 1'b0;
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        feedLast(1);
        checkOutput("p6.acc_out", int'($signed(accOutA)), 4);
        checkOutput("p6.acc_valid", int'(validA), 1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/booth_dot_accumulator.md
Name: booth_dot_accumulator

Overview:
- Downstream stage of the N-bit sequential Booth multiplier.
- Consumes each completed signed product (product/done pair) and sums LEN consecutive products into a signed saturating dot-product result.
- Presents the result on a valid/ready handshake, with a one-entry skid register so a product that finishes during back-pressure is not lost.

Parameters:
- N, 4, operand width of the upstream multiplier; product width is 2*N.
- LEN, 4, number of products per dot product; LEN >= 2.
- ACC_W, 12, accumulator/result width; ACC_W >= 2*N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of all state; priority over every other input.
- product_in  input  2*N  signed product from the multiplier.
- done_in  input  1  multiplier done level; it stays high until the next start.
- acc_out  output  ACC_W  signed dot-product result.
- acc_valid  output  1  acc_out holds a complete result.
- acc_ready  input  1  consumer accepts acc_out when acc_valid & acc_ready.
- sat_out  output  1  result was clamped; qualified by acc_valid.
- in_full  output  1  skid register occupied; upstream must not start a new multiply.
- drop_err  output  1  sticky: a product was discarded.
- term_cnt  output  clog2(LEN+1)  products summed into the current vector.

Behaviour:
- Reset: acc_out=0, acc_valid=0, sat_out=0, in_full=0, drop_err=0, term_cnt=0, state=ACCUM, done_q=0, pending cleared.
- Arrival: done_in is a level signal. An arrival is a rising clk edge with done_in=1 and done_q=0. done_q <= done_in every cycle.
- Sign extension: product_in is sign-extended to ACC_W bits.
- Adder: acc + term is computed in ACC_W+1 bits.
  - Above max(ACC_W) the result clamps to 2^(ACC_W-1)-1.
  - Below min(ACC_W) it clamps to -2^(ACC_W-1).
  - Either clamp sets the per-vector sat flag.
  - Further additions continue from the clamped value.
- State ACCUM: on arrival, acc <= sat(acc + term), term_cnt++.
  - When the arrival makes term_cnt == LEN: go to HOLD on the same edge, acc_valid=1, sat_out=vector sat flag.
  - Latency: acc_valid rises on the edge that registers the last term.
- State HOLD: acc_out and sat_out are stable until the handshake.
  - Arrival with pending empty: capture the product into pending; in_full=1.
  - Arrival with pending full: discard the product; drop_err=1 (sticky).
- Handshake in HOLD (acc_valid & acc_ready): acc_valid=0, next state ACCUM, new vector starts. The start value depends on pending and on a same-cycle arrival:
  - No pending, no arrival: acc=0, cnt=0.
  - Pending, no arrival: acc=sext(pending), cnt=1, in_full=0.
  - No pending, arrival: acc=sext(product_in), cnt=1.
  - Pending and arrival: acc=sat(pending+product_in), cnt=2. If LEN==2, return directly to HOLD with acc_valid=1.
  - The sat flag reflects only the new vector's terms.
- clear: acc=0, term_cnt=0, pending empty, in_full=0, acc_valid=0, sat_out=0, drop_err=0, state=ACCUM.
  - done_q still updates, so a done_in level held across clear is not re-counted.
- rst mid-vector: asynchronous return to reset values; a partial sum is lost.
- acc_ready while acc_valid=0: ignored.
- term_cnt never exceeds LEN.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Four done pulses, products 49, -56, 64, 10, acc_ready=1 (N=4, ACC_W=12) -> acc_valid on 4th arrival edge, acc_out=67, sat_out=0, term_cnt=4, then one-cycle acc_valid.
- done_in held high 10 cycles per product, products 5,5,5,5 -> counted once each, acc_out=20; clear while done_in high -> no spurious count.
- ACC_W=8, products 64,64,64,-1 -> clamp to 127, then 126; acc_out=126, sat_out=1. Next vector 1,1,1,1 -> acc_out=4, sat_out=0.
- acc_ready=0 after result 20; arrival 7 -> in_full=1; arrival 3 -> drop_err=1. Raise acc_ready -> new vector acc=7, term_cnt=1, in_full=0.
- HOLD with pending=7; acc_ready=1 in the same cycle as arrival -2 -> acc=5, term_cnt=2. Repeat with LEN=2 -> immediate acc_valid, acc_out=5.
- Assert rst after 2 terms (9, 9), then feed 1,1,1,1 -> acc_out=4; all outputs 0 during reset.
